// File: rtl/bin_to_gray_pkg.sv
// Shared Gray-code helpers and defaults for the bin_to_gray block and for
// any receiver that needs to encode or decode Gray pointers.
package gray_pkg;

    localparam int GRAY_W_DEFAULT = 4;
    localparam int GRAY_W_MAX     = 32;

    // Binary to Gray on a full-width word; narrower callers zero-extend
    // the argument and take the low bits of the result.
    function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary by running XOR from the MSB down. Zero-extended upper
    // bits leave the low bits unaffected.
    function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
        logic [GRAY_W_MAX-1:0] b;
        logic                  acc;
        acc = 1'b0;
        b   = '0;
        for (int i = GRAY_W_MAX-1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

endpackage

// File: rtl/bin_to_gray_if.sv
// Data/valid bundle between a producer of binary values and the
// bin_to_gray converter. The producer owns in_valid/B; the converter owns
// the Gray result and its self-check outputs.
interface bin_to_gray_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] G;
    logic             out_valid;
    logic [WIDTH-1:0] B_back;
    logic             err;

    modport master (
        output in_valid,
        output B,
        input  G,
        input  out_valid,
        input  B_back,
        input  err
    );

    modport slave (
        input  in_valid,
        input  B,
        output G,
        output out_valid,
        output B_back,
        output err
    );
endinterface

// File: rtl/bin_to_gray_dec.sv
// Purely combinational Gray-to-binary decoder. Each binary bit is the XOR
// of all Gray bits at or above it, so the loop carries a running XOR from
// the MSB downward.
module gray_to_bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Prefix-XOR chain from MSB to LSB
    always_comb begin
        logic acc;
        acc   = 1'b0;
        bin_o = '0;
        for (int i = WIDTH-1; i >= 0; i--) begin
            acc      = acc ^ gray_i[i];
            bin_o[i] = acc;
        end
    end

endmodule

// File: rtl/bin_to_gray.sv
// Registered binary-to-Gray converter with a one-cycle-later round-trip
// decode and mismatch flag, used as a built-in self-check on the encoder.
module bin_to_gray
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    bin_to_gray_if.slave bus
);

    // Stage 1: encode register, valid flag and captured source value
    logic [WIDTH-1:0]      g_q, g_d;
    logic [WIDTH-1:0]      bcap_q, bcap_d;
    logic                  vld_q, vld_d;
    logic [GRAY_W_MAX-1:0] g_full;

    // Stage 2: decoded value and compare result
    logic [WIDTH-1:0]      bback_q, bback_d;
    logic                  err_q, err_d;
    logic [WIDTH-1:0]      dec_w;

    // Encode next-state: load on accepted input, otherwise hold
    always_comb begin
        g_full = bin2gray(GRAY_W_MAX'(bus.B));
        g_d    = g_q;
        bcap_d = bcap_q;
        vld_d  = bus.in_valid;
        if (bus.in_valid) begin
            g_d    = g_full[WIDTH-1:0];
            bcap_d = bus.B;
        end
    end

    gray_to_bin #(
        .WIDTH (WIDTH)
    ) u_dec (
        .gray_i (g_q),
        .bin_o  (dec_w)
    );

    // Decode next-state: only refresh when stage 1 holds a fresh sample
    always_comb begin
        bback_d = bback_q;
        err_d   = err_q;
        if (vld_q) begin
            bback_d = dec_w;
            err_d   = (dec_w != bcap_q);
        end
    end

    // State registers; reset clears data too so outputs are never X and a
    // sample pending at the reset edge is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            g_q     <= '0;
            bcap_q  <= '0;
            vld_q   <= 1'b0;
            bback_q <= '0;
            err_q   <= 1'b0;
        end else begin
            g_q     <= g_d;
            bcap_q  <= bcap_d;
            vld_q   <= vld_d;
            bback_q <= bback_d;
            err_q   <= err_d;
        end
    end

    assign bus.G         = g_q;
    assign bus.out_valid = vld_q;
    assign bus.B_back    = bback_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_bin_to_gray.sv
// Testbench for bin_to_gray: directed table at WIDTH=4, random and counting
// streams at WIDTH=8, with a queue tracking the expected round-trip value.
module tb_bin_to_gray;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bin_to_gray_if #(.WIDTH(4)) if4 ();
    bin_to_gray_if #(.WIDTH(8)) if8 ();

    bin_to_gray #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    bin_to_gray #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [3:0] b;
        logic [3:0] g;
        logic       ov;
        string      nm;
    } vec_t;

    vec_t tbl[$];

    logic [3:0] q4[$];
    logic [3:0] exp_bb4;
    logic       acc_prev4;

    logic [7:0] b8q[$];
    logic [7:0] g8q[$];
    logic [7:0] exp_bb8;
    logic [7:0] last_g8;
    logic       acc_prev8;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic iv, input logic [3:0] b,
                                input logic [3:0] g, input logic ov, input string nm);
        vec_t v;
        v.rst = r; v.iv = iv; v.b = b; v.g = g; v.ov = ov; v.nm = nm;
        return v;
    endfunction

    task automatic step4(input vec_t v);
        @(negedge clk);
        rst          = v.rst;
        if4.in_valid = v.iv;
        if4.B        = v.b;
        if (v.iv && !v.rst) q4.push_back(v.b);
        @(posedge clk);
        #1;
        chk({v.nm, " G"}, 32'(if4.G), 32'(v.g));
        chk({v.nm, " out_valid"}, 32'(if4.out_valid), 32'(v.ov));
        if (v.rst) begin
            q4.delete();
            exp_bb4   = '0;
            acc_prev4 = 1'b0;
        end else begin
            if (acc_prev4 && q4.size() > 0) exp_bb4 = q4.pop_front();
            acc_prev4 = v.iv;
        end
        chk({v.nm, " B_back"}, 32'(if4.B_back), 32'(exp_bb4));
        chk({v.nm, " err"}, 32'(if4.err), 32'(0));
    endtask

    function automatic logic [7:0] gray8(input logic [7:0] b);
        logic [7:0] g;
        g[7] = b[7];
        for (int i = 6; i >= 0; i--) g[i] = b[i+1] ^ b[i];
        return g;
    endfunction

    task automatic step8(input logic iv, input logic [7:0] b, input string nm);
        logic [7:0] eg;
        @(negedge clk);
        rst          = 1'b0;
        if8.in_valid = iv;
        if8.B        = b;
        if (iv) begin
            b8q.push_back(b);
            g8q.push_back(gray8(b));
        end
        @(posedge clk);
        #1;
        if (iv) begin
            eg      = g8q.pop_front();
            last_g8 = eg;
        end
        chk({nm, " G"}, 32'(if8.G), 32'(last_g8));
        chk({nm, " out_valid"}, 32'(if8.out_valid), 32'(iv));
        if (acc_prev8 && b8q.size() > 0) exp_bb8 = b8q.pop_front();
        acc_prev8 = iv;
        chk({nm, " B_back"}, 32'(if8.B_back), 32'(exp_bb8));
        chk({nm, " err"}, 32'(if8.err), 32'(0));
    endtask

    initial begin
        logic [3:0] gseq [16];
        logic [7:0] prev_g;
        gseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

        rst          = 1'b1;
        if4.in_valid = 1'b1;
        if4.B        = 4'b1111;
        if8.in_valid = 1'b0;
        if8.B        = '0;
        exp_bb4      = '0;
        acc_prev4    = 1'b0;
        exp_bb8      = '0;
        last_g8      = '0;
        acc_prev8    = 1'b0;

        // Reset held two cycles with valid input present
        tbl.push_back(mk(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, "rst0"));
        tbl.push_back(mk(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, "rst1"));
        tbl.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, "post_rst"));
        // Exhaustive back-to-back sweep
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(1'b0, 1'b1, 4'(i), gseq[i], 1'b1, $sformatf("sweep%0d", i)));
        tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b1000, 1'b0, "sweep_end"));
        // Spot values
        tbl.push_back(mk(1'b0, 1'b1, 4'b0101, 4'b0111, 1'b1, "spot0101"));
        tbl.push_back(mk(1'b0, 1'b1, 4'b1010, 4'b1111, 1'b1, "spot1010"));
        tbl.push_back(mk(1'b0, 1'b1, 4'b1111, 4'b1000, 1'b1, "spot1111"));
        tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b1000, 1'b0, "spot_dec"));
        tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b1000, 1'b0, "spot_idle"));
        // Hold with gaps
        tbl.push_back(mk(1'b0, 1'b1, 4'b0011, 4'b0010, 1'b1, "hold_ld"));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b0, 1'b0, 4'b1100, 4'b0010, 1'b0, $sformatf("hold%0d", i)));
        // Reset mid-stream
        tbl.push_back(mk(1'b0, 1'b1, 4'b0101, 4'b0111, 1'b1, "mid_pre"));
        tbl.push_back(mk(1'b1, 1'b1, 4'b0110, 4'b0000, 1'b0, "mid_rst"));
        tbl.push_back(mk(1'b0, 1'b0, 4'b0110, 4'b0000, 1'b0, "mid_after0"));
        tbl.push_back(mk(1'b0, 1'b0, 4'b0110, 4'b0000, 1'b0, "mid_after1"));

        for (int i = 0; i < tbl.size(); i++) step4(tbl[i]);

        // Wide build: reset, then random stream
        if4.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("w8 rst G", 32'(if8.G), 32'(0));
        chk("w8 rst out_valid", 32'(if8.out_valid), 32'(0));
        chk("w8 rst B_back", 32'(if8.B_back), 32'(0));
        chk("w8 rst err", 32'(if8.err), 32'(0));

        for (int i = 0; i < 1000; i++)
            step8(($urandom_range(0, 3) != 0), 8'($urandom), "w8 rand");

        // Counting stream across the wrap; adjacent codes differ in one bit
        step8(1'b1, 8'd0, "w8 cnt");
        prev_g = if8.G;
        for (int i = 1; i <= 256; i++) begin
            step8(1'b1, 8'(i), "w8 cnt");
            chk("w8 adjacent one bit", 32'($countones(if8.G ^ prev_g)), 32'(1));
            prev_g = if8.G;
        end
        chk("w8 wrap G", 32'(prev_g), 32'(0));
        step8(1'b0, 8'd0, "w8 tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout actual=running required=done");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bin_to_gray.md
Name: bin_to_gray

Overview:
- Registered binary-to-Gray code converter with a valid qualifier.
- Used wherever a counter or index value must be sent across a boundary in Gray code, e.g. FIFO pointers headed for clock-domain synchronisers.
- Also produces a registered Gray-to-binary round-trip value and a mismatch flag for built-in self-checking.

Parameters:
- WIDTH, 4, bit width of the binary input and of the Gray output (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  B is sampled on the rising clk edge when high.
- B  input  WIDTH  binary value to convert.
- G  output  WIDTH  registered Gray code of the last accepted B.
- out_valid  output  1  high for exactly one cycle after each accepted input.
- B_back  output  WIDTH  registered Gray-to-binary decode of G (round-trip check).
- err  output  1  registered; high when B_back differs from the B that produced G.

Behaviour:
- Single clock domain. All outputs are registered on the rising clk edge.
- Reset: when rst is high at a clk edge, G=0, B_back=0, out_valid=0, err=0. rst has priority over in_valid.
- Encode: G[WIDTH-1] = B[WIDTH-1]; G[i] = B[i+1] XOR B[i] for i = WIDTH-2..0. Equivalent to G = B XOR (B >> 1).
- Encode latency: in_valid and B sampled at edge N; G and out_valid updated at edge N.
  - G is visible in the cycle after N.
  - out_valid is high for that one cycle.
- Hold: when in_valid is low, G holds its value and out_valid is 0 on the next cycle.
- Back-to-back: in_valid high on consecutive cycles gives one G update per cycle and out_valid held high continuously. No bubbles.
- Decode stage, one cycle after G:
  - B_back[WIDTH-1] = G[WIDTH-1]; B_back[i] = B_back[i+1] XOR G[i].
  - err = (B_back != B sample that produced G).
  - B_back and err update only when out_valid was high in the prior cycle; otherwise they hold.
  - A correct design never raises err. err exists as a verification hook.
- Reset mid-stream: any pending sample is discarded. No out_valid pulse follows a reset edge, even if in_valid was high at that edge.
- Wrap-around: B = all-ones encodes to G = 1 followed by WIDTH-1 zeros (4'b1000 for WIDTH=4). B=0 encodes to G=0.
- Adjacent inputs B and B+1 (mod 2^WIDTH) always give G values differing in exactly one bit. This holds across the all-ones to zero wrap.
- No X propagation: outputs are defined from the first reset onward regardless of B during reset.

Decomposition:
- Shared package gray_pkg:
  - function bin2gray(WIDTH-bit) returning WIDTH-bit.
  - function gray2bin(WIDTH-bit) returning WIDTH-bit.
  - default width constant GRAY_W_DEFAULT = 4.
- One sub-module is natural: gray_to_bin, a purely combinational WIDTH-parameterised decoder built as a prefix-XOR chain. It is instantiated for the B_back stage and is reusable by receivers of Gray pointers.
- Top level holds the encode register, the valid pipeline, the captured-B register for the compare, and the err compare.

Test Plan:
- Reset: rst=1 for 2 cycles with B=4'b1111 and in_valid=1 -> G=0000, out_valid=0, B_back=0000, err=0 on the cycle after rst falls.
- Exhaustive sweep, WIDTH=4: in_valid=1, B=0..15 on consecutive cycles -> G follows 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000 one cycle later; out_valid stays high; err stays 0.
- Spot values: B=0101 -> G=0111; B=1010 -> G=1111; B=1111 -> G=1000 and B_back=1111 one further cycle later.
- Hold/gaps: B=0011 with in_valid=1, then B=1100 with in_valid=0 for 3 cycles -> G stays 0010, out_valid pulses once then 0.
- Reset mid-stream: in_valid=1, B=0110, rst asserted at the same edge -> G=0000, out_valid=0; no stale 0101 appears afterwards.
- Wide build, WIDTH=8, random 1000 samples:
  - G equals B ^ (B>>1) one cycle later.
  - Successive G values for B and B+1 differ by one bit (255 -> 0 gives 10000000 -> 00000000).
  - err never asserts.
